// File: rtl/player_ship_if.sv
// Bundle of pixel, control and status signals exchanged between the video
// pipeline and the player ship generator.
interface player_ship_if #(parameter int NUM_LASERS = 4);
  logic                      video_on;
  logic [9:0]                x;
  logic [9:0]                y;
  logic                      left;
  logic                      right;
  logic                      shoot;
  logic                      ship_hit;
  logic [NUM_LASERS-1:0]     laser_hit;
  logic                      ship_on;
  logic [NUM_LASERS-1:0]     laser_on;
  logic [9:0]                ship_x;
  logic [10*NUM_LASERS-1:0]  laser_x;
  logic [10*NUM_LASERS-1:0]  laser_y;
  logic [NUM_LASERS-1:0]     laser_active;
  logic [3:0]                lives;
  logic                      game_over;

  modport master (
    output video_on, x, y, left, right, shoot, ship_hit, laser_hit,
    input  ship_on, laser_on, ship_x, laser_x, laser_y, laser_active, lives, game_over
  );

  modport slave (
    input  video_on, x, y, left, right, shoot, ship_hit, laser_hit,
    output ship_on, laser_on, ship_x, laser_x, laser_y, laser_active, lives, game_over
  );
endinterface

// File: rtl/player_ship_gen.sv
// Player ship generator: ship motion, multi-slot laser magazine with fire
// cooldown, and a lives/respawn state machine with blink invulnerability.
module player_ship_gen #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int SHIP_W         = 40,
  parameter int SHIP_H         = 20,
  parameter int SHIP_VEL       = 2,
  parameter int LASER_W        = 4,
  parameter int LASER_H        = 8,
  parameter int LASER_VEL      = 3,
  parameter int NUM_LASERS     = 4,
  parameter int COOLDOWN       = 15,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120
) (
  input  logic          clk,
  input  logic          reset,
  player_ship_if.slave  bus
);

  localparam logic [9:0] X_MAX     = 10'(SCREEN_W - SHIP_W);
  localparam logic [9:0] X_HOME    = 10'((SCREEN_W - SHIP_W) / 2);
  localparam logic [9:0] SHIP_T    = 10'(SCREEN_H - SHIP_H);
  localparam logic [9:0] SHIP_B    = 10'(SCREEN_H - 1);
  localparam logic [9:0] TICK_Y    = 10'(SCREEN_H + 1);
  localparam logic [9:0] VEL       = 10'(SHIP_VEL);
  localparam logic [9:0] LVEL      = 10'(LASER_VEL);
  localparam logic [9:0] LASER_DX  = 10'((SHIP_W - LASER_W) / 2);
  localparam logic [9:0] LASER_Y0  = 10'(SCREEN_H - SHIP_H - LASER_H);
  localparam logic [9:0] SHIP_WM1  = 10'(SHIP_W - 1);
  localparam logic [9:0] LASER_WM1 = 10'(LASER_W - 1);
  localparam logic [9:0] LASER_HM1 = 10'(LASER_H - 1);
  localparam logic [6:0] T_EXPLODE = 7'(EXPLODE_FRAMES);
  localparam logic [6:0] T_INVULN  = 7'(INVULN_FRAMES);
  localparam logic [3:0] LIVES0    = 4'(LIVES);
  localparam logic [7:0] CD0       = 8'(COOLDOWN);

  typedef enum logic [1:0] {ALIVE, EXPLODE, RESPAWN, DEAD} state_t;

  state_t                state_q, state_d;
  logic [6:0]            timer_q, timer_d;
  logic [3:0]            lives_q, lives_d;
  logic [9:0]            ship_x_q, ship_x_d;
  logic [7:0]            cooldown_q;
  logic                  fire_req_q;
  logic                  shoot_d_q;
  logic [NUM_LASERS-1:0] active_q;
  logic [NUM_LASERS-1:0] fire_slot;
  logic [9:0]            lx_q [NUM_LASERS];
  logic [9:0]            ly_q [NUM_LASERS];
  logic                  frame_tick, can_act, slot_found, fire_go, visible;

  function automatic logic [9:0] step_x(input logic [9:0] sx, input logic l, input logic r);
    if (r && !l)      return (sx >= X_MAX - VEL) ? X_MAX : sx + VEL;
    else if (l && !r) return (sx < VEL) ? 10'd0 : sx - VEL;
    return sx;
  endfunction

  assign frame_tick = (bus.y == TICK_Y) && (bus.x == 10'd0);
  assign can_act    = (state_q == ALIVE) || (state_q == RESPAWN);

  // Lowest-index free slot, one-hot
  always_comb begin
    fire_slot  = '0;
    slot_found = 1'b0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (!active_q[i] && !slot_found) begin
        fire_slot[i] = 1'b1;
        slot_found   = 1'b1;
      end
    end
  end

  assign fire_go = frame_tick && fire_req_q && (cooldown_q == 8'd0) && can_act && slot_found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ALIVE;
      timer_q  <= '0;
      lives_q  <= LIVES0;
      ship_x_q <= X_HOME;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lives_q  <= lives_d;
      ship_x_q <= ship_x_d;
    end
  end

  // Timers count down on frame ticks; the transition happens on the tick that reaches zero
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    lives_d  = lives_q;
    ship_x_d = ship_x_q;
    case (state_q)
      ALIVE: begin
        if (bus.ship_hit) begin
          state_d = EXPLODE;
          timer_d = T_EXPLODE;
          if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
        end else if (frame_tick) begin
          ship_x_d = step_x(ship_x_q, bus.left, bus.right);
        end
      end
      EXPLODE: begin
        if (frame_tick) begin
          if (timer_q <= 7'd1) begin
            timer_d = '0;
            if (lives_q != 4'd0) begin
              state_d  = RESPAWN;
              timer_d  = T_INVULN;
              ship_x_d = X_HOME;
            end else begin
              state_d = DEAD;
            end
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      RESPAWN: begin
        if (frame_tick) begin
          ship_x_d = step_x(ship_x_q, bus.left, bus.right);
          if (timer_q <= 7'd1) begin
            state_d = ALIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Fire request and cooldown; a shoot edge sampled on the tick itself is not carried over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shoot_d_q  <= 1'b0;
      fire_req_q <= 1'b0;
      cooldown_q <= '0;
    end else begin
      shoot_d_q  <= bus.shoot;
      fire_req_q <= frame_tick ? 1'b0 : (fire_req_q | (bus.shoot & ~shoot_d_q));
      if (frame_tick) begin
        if (fire_go)                 cooldown_q <= CD0;
        else if (cooldown_q != 8'd0) cooldown_q <= cooldown_q - 8'd1;
      end
    end
  end

  // Laser slots: firing targets only free slots, so a hit always clears an active one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '0;
      for (int i = 0; i < NUM_LASERS; i++) begin
        lx_q[i] <= '0;
        ly_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LASERS; i++) begin
        if (state_q == DEAD) begin
          active_q[i] <= 1'b0;
        end else if (fire_go && fire_slot[i]) begin
          active_q[i] <= 1'b1;
          lx_q[i]     <= ship_x_q + LASER_DX;
          ly_q[i]     <= LASER_Y0;
        end else if (bus.laser_hit[i]) begin
          active_q[i] <= 1'b0;
        end else if (frame_tick && active_q[i]) begin
          if (ly_q[i] < LVEL) active_q[i] <= 1'b0;
          else                ly_q[i]     <= ly_q[i] - LVEL;
        end
      end
    end
  end

  assign visible        = (state_q == ALIVE) || ((state_q == RESPAWN) && !timer_q[3]);
  assign bus.ship_on    = bus.video_on && visible &&
                          (bus.x >= ship_x_q) && (bus.x <= ship_x_q + SHIP_WM1) &&
                          (bus.y >= SHIP_T) && (bus.y <= SHIP_B);
  assign bus.ship_x       = ship_x_q;
  assign bus.laser_active = active_q;
  assign bus.lives        = lives_q;
  assign bus.game_over    = (state_q == DEAD);

  for (genvar g = 0; g < NUM_LASERS; g++) begin : g_laser_out
    assign bus.laser_x[10*g +: 10] = lx_q[g];
    assign bus.laser_y[10*g +: 10] = ly_q[g];
    assign bus.laser_on[g] = bus.video_on && active_q[g] &&
                             (bus.x >= lx_q[g]) && (bus.x <= lx_q[g] + LASER_WM1) &&
                             (bus.y >= ly_q[g]) && (bus.y <= ly_q[g] + LASER_HM1);
  end

endmodule

// File: tb/tb_player_ship_gen.sv
// Bench for player_ship_gen: directed scenarios plus randomized play checked
// against a frame-count based reference model.
module tb_player_ship_gen;
  localparam int NL    = 4;
  localparam int HOME  = 300;
  localparam int XMAX  = 600;
  localparam int COOL  = 15;
  localparam int EXPL  = 60;
  localparam int INV   = 120;
  localparam int LY0   = 452;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  player_ship_if #(.NUM_LASERS(NL)) ifc ();
  player_ship_gen #(.NUM_LASERS(NL)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phases derived from ticks elapsed since the last accepted hit
  int m_tick, m_hit_tick, m_lives, m_ship_x, m_last_fire;
  bit m_fire_req;
  bit m_act [NL];
  int m_lx [NL];
  int m_ly [NL];

  function automatic int phase();  // 0 alive, 1 exploding, 2 respawning, 3 dead
    int d;
    if (m_hit_tick < 0) return 0;
    d = m_tick - m_hit_tick;
    if (d < EXPL) return 1;
    if (m_lives == 0) return 3;
    if (d < EXPL + INV) return 2;
    return 0;
  endfunction

  function automatic bit ship_vis();
    int p = phase();
    if (p == 0) return 1'b1;
    if (p == 2) return (((INV - (m_tick - m_hit_tick - EXPL)) & 8) == 0);
    return 1'b0;
  endfunction

  function automatic logic [NL-1:0] exp_act();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_reset();
    m_tick = 0; m_hit_tick = -1; m_lives = 3; m_ship_x = HOME;
    m_last_fire = -1000; m_fire_req = 1'b0;
    for (int i = 0; i < NL; i++) begin m_act[i] = 1'b0; m_lx[i] = 0; m_ly[i] = 0; end
  endtask

  task automatic model_tick();
    int p = phase();
    int fired = -1;
    if ((p == 0 || p == 2) && m_fire_req && (m_tick - m_last_fire > COOL))
      for (int i = NL - 1; i >= 0; i--) if (!m_act[i]) fired = i;
    for (int i = 0; i < NL; i++) begin
      if (i == fired) begin
        m_act[i] = 1'b1; m_lx[i] = m_ship_x + 18; m_ly[i] = LY0;
      end else if (m_act[i]) begin
        if (m_ly[i] < 3) m_act[i] = 1'b0;
        else m_ly[i] -= 3;
      end
    end
    if (fired >= 0) m_last_fire = m_tick;
    if (p == 0 || p == 2) begin
      if (ifc.right && !ifc.left) m_ship_x = (m_ship_x + 2 > XMAX) ? XMAX : m_ship_x + 2;
      else if (ifc.left && !ifc.right) m_ship_x = (m_ship_x < 2) ? 0 : m_ship_x - 2;
    end
    m_fire_req = 1'b0;
    m_tick++;
    if (m_hit_tick >= 0 && m_tick - m_hit_tick == EXPL && m_lives > 0) m_ship_x = HOME;
    if (phase() == 3) for (int i = 0; i < NL; i++) m_act[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    ifc.video_on = 1'b1; ifc.x = 10'd5; ifc.y = 10'd0;
    ifc.left = 1'b0; ifc.right = 1'b0; ifc.shoot = 1'b0;
    ifc.ship_hit = 1'b0; ifc.laser_hit = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_tick();
    @(negedge clk); ifc.x = 10'd0; ifc.y = 10'd481;
    @(negedge clk); ifc.x = 10'd5; ifc.y = 10'd0;
    model_tick();
  endtask

  task automatic pulse_shoot();
    @(negedge clk); ifc.shoot = 1'b1;
    @(negedge clk); ifc.shoot = 1'b0;
    m_fire_req = 1'b1;
  endtask

  task automatic pulse_laser_hit(input int i);
    @(negedge clk); ifc.laser_hit = NL'(1) << i;
    @(negedge clk); ifc.laser_hit = '0;
    m_act[i] = 1'b0;
  endtask

  task automatic pulse_ship_hit();
    @(negedge clk); ifc.ship_hit = 1'b1;
    @(negedge clk); ifc.ship_hit = 1'b0;
    if (phase() == 0) begin m_lives--; m_hit_tick = m_tick; end
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    if (ifc.ship_x !== 10'd300) begin n_bad++; $display("FAIL reset_ship_x got %0d want 300", ifc.ship_x); end
    n_cmp++;
    if (ifc.lives !== 4'd3) begin n_bad++; $display("FAIL reset_lives got %0d want 3", ifc.lives); end
    n_cmp++;
    if (ifc.game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over got %0b want 0", ifc.game_over); end
    n_cmp++;
    if (ifc.laser_active !== 4'b0) begin n_bad++; $display("FAIL reset_active got %b want 0000", ifc.laser_active); end
    n_cmp++;
    if (ifc.laser_x !== 40'd0 || ifc.laser_y !== 40'd0) begin
      n_bad++; $display("FAIL reset_laser_xy got %h/%h want 0", ifc.laser_x, ifc.laser_y);
    end
    n_cmp++;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_move();
    do_reset();
    ifc.right = 1'b1;
    repeat (10) do_tick();
    if (ifc.ship_x !== 10'd320) begin n_bad++; $display("FAIL move_right10 got %0d want 320", ifc.ship_x); end
    n_cmp++;
    repeat (200) do_tick();
    if (ifc.ship_x !== 10'd600) begin n_bad++; $display("FAIL move_sat_right got %0d want 600", ifc.ship_x); end
    n_cmp++;
    ifc.right = 1'b0; ifc.left = 1'b1;
    repeat (400) do_tick();
    if (ifc.ship_x !== 10'd0) begin n_bad++; $display("FAIL move_sat_left got %0d want 0", ifc.ship_x); end
    n_cmp++;
    for (int k = 0; k < 40; k++) begin
      ifc.left = 1'($urandom_range(0, 1)); ifc.right = 1'($urandom_range(0, 1));
      do_tick();
      if (ifc.ship_x !== 10'(m_ship_x)) begin
        n_bad++; $display("FAIL move_random[%0d] got %0d want %0d", k, ifc.ship_x, m_ship_x);
      end
      n_cmp++;
    end
    ifc.left = 1'b0; ifc.right = 1'b0;
  endtask

  task automatic test_fire_single();
    int n;
    int want;
    do_reset();
    pulse_shoot();
    do_tick();
    if (ifc.laser_active !== 4'b0001 || ifc.laser_x[9:0] !== 10'd318 || ifc.laser_y[9:0] !== 10'd452) begin
      n_bad++; $display("FAIL fire_first got act=%b x=%0d y=%0d want 0001/318/452",
                        ifc.laser_active, ifc.laser_x[9:0], ifc.laser_y[9:0]);
    end
    n_cmp++;
    repeat (5) do_tick();
    if (ifc.laser_y[9:0] !== 10'd437) begin n_bad++; $display("FAIL fire_move5 got %0d want 437", ifc.laser_y[9:0]); end
    n_cmp++;
    want = LY0 / 3 + 1 - 5;
    n = 0;
    while (ifc.laser_active[0] === 1'b1 && n < 300) begin do_tick(); n++; end
    if (n != want) begin n_bad++; $display("FAIL fire_expire_ticks got %0d want %0d", n, want); end
    n_cmp++;
    if (ifc.laser_active !== 4'b0) begin n_bad++; $display("FAIL fire_expired_active got %b want 0000", ifc.laser_active); end
    n_cmp++;
  endtask

  task automatic test_magazine();
    do_reset();
    @(negedge clk); ifc.shoot = 1'b1; m_fire_req = 1'b1;
    repeat (20) do_tick();
    ifc.shoot = 1'b0;
    if (ifc.laser_active !== 4'b0001) begin n_bad++; $display("FAIL hold_single got %b want 0001", ifc.laser_active); end
    n_cmp++;
    for (int k = 1; k <= 3; k++) begin
      pulse_shoot(); do_tick();
      if (ifc.laser_active !== 4'((1 << (k + 1)) - 1)) begin
        n_bad++; $display("FAIL mag_fill[%0d] got %b want %b", k, ifc.laser_active, 4'((1 << (k + 1)) - 1));
      end
      n_cmp++;
      repeat (19) do_tick();
    end
    pulse_shoot(); do_tick();
    for (int i = 0; i < NL; i++) begin
      if (ifc.laser_active[i] !== 1'b1 || ifc.laser_y[10*i +: 10] !== 10'(m_ly[i])) begin
        n_bad++; $display("FAIL mag_full_drop[%0d] got act=%b y=%0d want 1/%0d", i, ifc.laser_active[i], ifc.laser_y[10*i +: 10], m_ly[i]);
      end
      n_cmp++;
    end
    pulse_laser_hit(1);
    if (ifc.laser_active !== 4'b1101) begin n_bad++; $display("FAIL hit_clear1 got %b want 1101", ifc.laser_active); end
    n_cmp++;
    pulse_shoot(); do_tick();
    if (ifc.laser_active !== 4'b1111 || ifc.laser_y[19:10] !== 10'd452 || ifc.laser_x[19:10] !== 10'(m_ship_x + 18)) begin
      n_bad++; $display("FAIL reuse_slot1 got act=%b y=%0d x=%0d want 1111/452/%0d",
                        ifc.laser_active, ifc.laser_y[19:10], ifc.laser_x[19:10], m_ship_x + 18);
    end
    n_cmp++;
    pulse_laser_hit(2);
    repeat (5) do_tick();
    pulse_shoot(); do_tick();
    if (ifc.laser_active[2] !== 1'b0) begin n_bad++; $display("FAIL cooldown_drop6 got %b want 0", ifc.laser_active[2]); end
    n_cmp++;
    repeat (8) do_tick();
    pulse_shoot(); do_tick();
    if (ifc.laser_active[2] !== 1'b0) begin n_bad++; $display("FAIL cooldown_drop15 got %b want 0", ifc.laser_active[2]); end
    n_cmp++;
    pulse_shoot(); do_tick();
    if (ifc.laser_active[2] !== 1'b1 || ifc.laser_y[29:20] !== 10'd452) begin
      n_bad++; $display("FAIL cooldown_fire16 got act=%b y=%0d want 1/452", ifc.laser_active[2], ifc.laser_y[29:20]);
    end
    n_cmp++;
  endtask

  task automatic test_ship_hit();
    do_reset();
    pulse_ship_hit();
    if (ifc.lives !== 4'd2) begin n_bad++; $display("FAIL hit_lives got %0d want 2", ifc.lives); end
    n_cmp++;
    ifc.right = 1'b1;
    for (int k = 0; k < EXPL; k++) begin
      ifc.x = 10'(m_ship_x + 5); ifc.y = 10'd465; #1;
      if (ifc.ship_on !== 1'b0) begin n_bad++; $display("FAIL explode_hidden[%0d] got 1 want 0", k); end
      n_cmp++;
      do_tick();
    end
    ifc.right = 1'b0;
    if (ifc.ship_x !== 10'd300) begin n_bad++; $display("FAIL respawn_home got %0d want 300", ifc.ship_x); end
    n_cmp++;
    for (int k = 0; k < INV; k++) begin
      if (k == 30) pulse_ship_hit();
      ifc.x = 10'(m_ship_x + 5); ifc.y = 10'd465; #1;
      if (ifc.ship_on !== ship_vis()) begin
        n_bad++; $display("FAIL blink[%0d] got %b want %b", k, ifc.ship_on, ship_vis());
      end
      n_cmp++;
      do_tick();
    end
    if (ifc.lives !== 4'd2) begin n_bad++; $display("FAIL invuln_lives got %0d want 2", ifc.lives); end
    n_cmp++;
    ifc.x = 10'(m_ship_x + 5); ifc.y = 10'd465; #1;
    if (ifc.ship_on !== 1'b1) begin n_bad++; $display("FAIL alive_again got %b want 1", ifc.ship_on); end
    n_cmp++;
  endtask

  task automatic test_game_over();
    pulse_ship_hit();
    repeat (EXPL + INV) do_tick();
    if (ifc.lives !== 4'd1 || ifc.game_over !== 1'b0) begin
      n_bad++; $display("FAIL second_hit got lives=%0d go=%b want 1/0", ifc.lives, ifc.game_over);
    end
    n_cmp++;
    pulse_shoot(); do_tick();
    pulse_ship_hit();
    repeat (EXPL - 1) do_tick();
    if (ifc.game_over !== 1'b0 || ifc.laser_active === 4'b0) begin
      n_bad++; $display("FAIL pre_dead got go=%b act=%b want 0/nonzero", ifc.game_over, ifc.laser_active);
    end
    n_cmp++;
    do_tick();
    @(negedge clk);
    if (ifc.game_over !== 1'b1 || ifc.lives !== 4'd0 || ifc.laser_active !== 4'b0) begin
      n_bad++; $display("FAIL dead got go=%b lives=%0d act=%b want 1/0/0000", ifc.game_over, ifc.lives, ifc.laser_active);
    end
    n_cmp++;
    ifc.left = 1'b1;
    pulse_shoot(); pulse_ship_hit();
    repeat (20) do_tick();
    ifc.left = 1'b0;
    if (ifc.laser_active !== 4'b0 || ifc.ship_x !== 10'(m_ship_x) || ifc.lives !== 4'd0 || ifc.game_over !== 1'b1) begin
      n_bad++; $display("FAIL dead_stays got act=%b x=%0d lives=%0d go=%b want 0000/%0d/0/1",
                        ifc.laser_active, ifc.ship_x, ifc.lives, ifc.game_over, m_ship_x);
    end
    n_cmp++;
    @(negedge clk); #2 reset = 1'b1; #1;
    if (ifc.lives !== 4'd3 || ifc.game_over !== 1'b0 || ifc.ship_x !== 10'd300) begin
      n_bad++; $display("FAIL async_reset got lives=%0d go=%b x=%0d want 3/0/300", ifc.lives, ifc.game_over, ifc.ship_x);
    end
    n_cmp++;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int i;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ifc.left = 1'($urandom_range(0, 1)); ifc.right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pulse_shoot();
      if ($urandom_range(0, 7) == 0) pulse_laser_hit(int'($urandom_range(0, NL - 1)));
      if ($urandom_range(0, 79) == 0) pulse_ship_hit();
      do_tick();
      @(negedge clk);
      if (ifc.ship_x !== 10'(m_ship_x) || ifc.lives !== 4'(m_lives) ||
          ifc.game_over !== (phase() == 3) || ifc.laser_active !== exp_act()) begin
        n_bad++; $display("FAIL rnd_state[%0d] got x=%0d l=%0d go=%b act=%b want %0d/%0d/%b/%b", k,
                          ifc.ship_x, ifc.lives, ifc.game_over, ifc.laser_active, m_ship_x, m_lives, phase() == 3, exp_act());
      end
      n_cmp++;
      for (int s = 0; s < NL; s++) begin
        if (m_act[s] && (ifc.laser_x[10*s +: 10] !== 10'(m_lx[s]) || ifc.laser_y[10*s +: 10] !== 10'(m_ly[s]))) begin
          n_bad++; $display("FAIL rnd_laser[%0d][%0d] got %0d,%0d want %0d,%0d", k, s,
                            ifc.laser_x[10*s +: 10], ifc.laser_y[10*s +: 10], m_lx[s], m_ly[s]);
        end
        n_cmp++;
      end
      ifc.video_on = 1'($urandom_range(0, 7) != 0);
      ifc.x = 10'(m_ship_x + 39); ifc.y = 10'd479; #1;
      if (ifc.ship_on !== (ifc.video_on && ship_vis())) begin
        n_bad++; $display("FAIL rnd_ship_edge[%0d] got %b want %b", k, ifc.ship_on, ifc.video_on && ship_vis());
      end
      n_cmp++;
      ifc.x = 10'(m_ship_x + 40); #1;
      if (ifc.ship_on !== 1'b0) begin n_bad++; $display("FAIL rnd_ship_out[%0d] got 1 want 0", k); end
      n_cmp++;
      i = int'($urandom_range(0, NL - 1));
      ifc.x = 10'(m_lx[i] + 3); ifc.y = 10'(m_ly[i] + 7); #1;
      if (ifc.laser_on[i] !== (ifc.video_on && m_act[i])) begin
        n_bad++; $display("FAIL rnd_laser_on[%0d][%0d] got %b want %b", k, i, ifc.laser_on[i], ifc.video_on && m_act[i]);
      end
      n_cmp++;
      ifc.x = 10'(m_lx[i] + 4); #1;
      if (ifc.laser_on[i] !== 1'b0) begin n_bad++; $display("FAIL rnd_laser_out[%0d][%0d] got 1 want 0", k, i); end
      n_cmp++;
      ifc.video_on = 1'b1; ifc.x = 10'd5; ifc.y = 10'd0;
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_fire_single();
    test_magazine();
    test_ship_hit();
    test_game_over();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
